seg7_scan_decoder: RTL

//  Passive monitor for the Nexys4 multiplexed 7-segment bus: samples anode and cathode lines,

---
 rtl/seg7_scan_decoder_pkg.sv | 31 +++
 rtl/seg7_pattern_to_bcd.sv | 40 ++++
 rtl/seg7_scan_decoder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_pkg.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder_pkg
//   Shared definitions for the 7-segment scan decoder.
//   Cathode patterns are active-low, bit6 = segment a .. bit0 = segment g.
//   The same constants serve the digit-to-cathode encoder side.
// ---------------------------------------------------------------------------
package seg7_scan_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  // Scan-sampling FSM: wait for a stable dwell, take one sample, then hold
  // until the bus moves again.
  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// ---------------------------------------------------------------------------
// seg7_pattern_to_bcd
//   Combinational inverse of the digit-to-cathode encoder. Only exact
//   patterns for 0-9 are accepted; anything else (including blank) yields
//   BCD_INVALID with invalid=1.
// Ports
//   cathode  in   7  active-low segment pattern, bit6=a .. bit0=g
//   bcd      out  4  decoded digit, or 4'hF when unrecognised
//   invalid  out  1  pattern was not one of the ten digit patterns
// ---------------------------------------------------------------------------
module seg7_pattern_to_bcd
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] cathode,
  output logic [3:0] bcd,
  output logic       invalid
);

  always_comb begin
    bcd     = BCD_INVALID;
    invalid = 1'b0;
    case (cathode)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: begin
        bcd     = BCD_INVALID;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//   Passive monitor of a multiplexed 7-segment bus. Samples anode/cathode
//   once per stable dwell, maps the cathode pattern back to BCD and
//   assembles a full frame of digits once every digit has been seen.
// Ports
//   clk          in   1             system clock
//   reset        in   1             synchronous, active-high
//   anode        in   NUM_DIGITS    active-low digit enables, bit i = digit i
//   cathode      in   7             active-low segments, bit6=a .. bit0=g
//   digits       out  4*NUM_DIGITS  last complete frame, digit i in [4i+3:4i]
//   digit_err    out  NUM_DIGITS    digit i of last frame was unrecognised
//   frame_valid  out  1             one-cycle pulse when digits/digit_err update
//   anode_fault  out  1             sticky: a settled sample had 0 or >1 anodes low
// ---------------------------------------------------------------------------
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SETTLE_CYCLES = 16
)
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_DIGITS-1:0]     anode,
  input  logic [6:0]                cathode,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     digit_err,
  output logic                      frame_valid,
  output logic                      anode_fault
);

  localparam int BUS_W = NUM_DIGITS + 7;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  // Two-flop synchroniser; bus_q is the synchronised {anode, cathode}.
  logic [BUS_W-1:0]        sync_q, bus_q, prev_q;
  logic [BUS_W-1:0]        sample_q, sample_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  scan_state_t             state_q, state_d;
  logic [3:0]              shadow_q [NUM_DIGITS];
  logic [3:0]              shadow_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   err_sh_q, err_sh_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   digit_err_q, digit_err_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    anode_fault_q, anode_fault_d;

  logic                    bus_changed;
  logic [NUM_DIGITS-1:0]   sample_onehot, onehot_m1;
  logic [6:0]              sample_cathode;
  logic                    single_anode;
  logic [IDX_W-1:0]        anode_idx;
  logic [3:0]              dec_bcd;
  logic                    dec_invalid;

  assign bus_changed    = (bus_q != prev_q);
  assign sample_onehot  = ~sample_q[BUS_W-1:7];
  assign sample_cathode = sample_q[6:0];

  // Exactly-one-low check is independent of the index encoder below.
  assign onehot_m1    = sample_onehot - NUM_DIGITS'(1);
  assign single_anode = (sample_onehot != '0) && ((sample_onehot & onehot_m1) == '0);

  // Priority-free one-hot to index: index bit gi is the OR of every one-hot
  // position whose binary index has bit gi set. Only meaningful when
  // single_anode is true.
  genvar gi, gj;
  generate
    for (gi = 0; gi < IDX_W; gi++) begin : g_idx
      logic [NUM_DIGITS-1:0] hits;
      for (gj = 0; gj < NUM_DIGITS; gj++) begin : g_bit
        assign hits[gj] = sample_onehot[gj] & (((gj >> gi) & 1) == 1);
      end
      assign anode_idx[gi] = |hits;
    end
  endgenerate

  seg7_pattern_to_bcd u_pattern_to_bcd (
    .cathode (sample_cathode),
    .bcd     (dec_bcd),
    .invalid (dec_invalid)
  );

  always_comb begin
    state_d       = state_q;
    sample_d      = sample_q;
    shadow_d      = shadow_q;
    err_sh_d      = err_sh_q;
    seen_d        = seen_q;
    digits_d      = digits_q;
    digit_err_d   = digit_err_q;
    frame_valid_d = 1'b0;
    anode_fault_d = anode_fault_q;

    // Stability counter: restarts on any bus movement, saturates at the
    // settle length.
    if (bus_changed) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_SETTLE: begin
        // Total latency from a pin change: 2 synchroniser cycles plus the
        // settle window.
        if (!bus_changed && (cnt_q == CNT_W'(SETTLE_CYCLES - 1))) begin
          state_d  = ST_SAMPLE;
          sample_d = bus_q;
        end
      end

      ST_SAMPLE: begin
        if (single_anode) begin
          shadow_d[anode_idx] = dec_bcd;
          err_sh_d[anode_idx] = dec_invalid;
          seen_d[anode_idx]   = 1'b1;
        end else begin
          anode_fault_d = 1'b1;
        end

        // Frame completes with this sample: outputs load at the end of
        // this cycle and are visible in the following one.
        if (&seen_d) begin
          for (int k = 0; k < NUM_DIGITS; k++) begin
            digits_d[4*k +: 4] = shadow_d[k];
          end
          digit_err_d   = err_sh_d;
          frame_valid_d = 1'b1;
          seen_d        = '0;
        end

        // If the bus already moved during this cycle, go straight back to
        // settling so the new dwell is not lost while waiting in HOLD.
        state_d = bus_changed ? ST_SETTLE : ST_HOLD;
      end

      ST_HOLD: begin
        if (bus_changed) begin
          state_d = ST_SETTLE;
        end
      end

      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= '0;
      bus_q         <= '0;
      prev_q        <= '0;
      sample_q      <= '0;
      cnt_q         <= '0;
      state_q       <= ST_SETTLE;
      err_sh_q      <= '0;
      seen_q        <= '0;
      digits_q      <= '0;
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
      anode_fault_q <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      sync_q        <= {anode, cathode};
      bus_q         <= sync_q;
      prev_q        <= bus_q;
      sample_q      <= sample_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      err_sh_q      <= err_sh_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      digit_err_q   <= digit_err_d;
      frame_valid_q <= frame_valid_d;
      anode_fault_q <= anode_fault_d;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign digits      = digits_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign anode_fault = anode_fault_q;

endmodule
